// File: rtl/addr_range_matcher.sv
// Address range matcher: NUM_WIN programmable windows flag hits on a sniffed bus address, with per-window hit counters.
// Latency 2 cycles from valid/B to hit/hit_vec at one address per cycle; no backpressure, and config writes never stall the pipe.
module addr_range_matcher #(
    parameter int WIDTH     = 32,
    parameter int NUM_WIN   = 4,
    parameter int CNT_WIDTH = 16,
    parameter int SEL_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [SEL_W-1:0]     cfg_sel,
    input  logic [WIDTH-1:0]     cfg_lo,
    input  logic [WIDTH-1:0]     cfg_hi,
    input  logic [1:0]           cfg_mode,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     B,
    output logic                 hit,
    output logic [NUM_WIN-1:0]   hit_vec,
    input  logic [SEL_W-1:0]     cnt_sel,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] cnt_out
);

    localparam logic [1:0] MODE_INSIDE  = 2'b01;
    localparam logic [1:0] MODE_OUTSIDE = 2'b10;

    logic [WIDTH-1:0]     r_lo   [NUM_WIN];
    logic [WIDTH-1:0]     r_hi   [NUM_WIN];
    logic [1:0]           r_mode [NUM_WIN];
    logic [CNT_WIDTH-1:0] r_cnt  [NUM_WIN];
    logic [NUM_WIN-1:0]   r_s1_match;

    logic [NUM_WIN-1:0]   w_cfg_wr;
    logic [NUM_WIN-1:0]   w_match;
    logic [CNT_WIDTH-1:0] w_cnt_sel_val;

    // Out-of-range selects simply decode to no window, which drops the write.
    always_comb begin
        w_cfg_wr = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            w_cfg_wr[i] = cfg_we && (cfg_sel == SEL_W'(i));
        end
    end

    // lo > hi needs no special case: the inside test can never pass, so outside always does.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            case (r_mode[i])
                MODE_INSIDE:  w_match[i] = (B >= r_lo[i]) && (B <= r_hi[i]);
                MODE_OUTSIDE: w_match[i] = (B < r_lo[i]) || (B > r_hi[i]);
                default:      w_match[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_cnt_sel_val = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                w_cnt_sel_val = r_cnt[i];
            end
        end
    end

    // Window registers update on the same edge that samples B, so that address sees the old values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                r_lo[i]   <= '1;
                r_hi[i]   <= '1;
                r_mode[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (w_cfg_wr[i]) begin
                    r_lo[i]   <= cfg_lo;
                    r_hi[i]   <= cfg_hi;
                    r_mode[i] <= cfg_mode;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_match <= '0;
            hit_vec    <= '0;
            hit        <= 1'b0;
        end else begin
            r_s1_match <= valid ? w_match : '0;
            hit_vec    <= r_s1_match;
            hit        <= |r_s1_match;
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                r_cnt[i] <= '0;
            end
            cnt_out <= '0;
        end else begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (cnt_clr) begin
                    r_cnt[i] <= '0;
                end else if (hit_vec[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
            cnt_out <= w_cnt_sel_val;
        end
    end

endmodule

// File: tb/tb_addr_range_matcher.sv
// Randomised and directed bench for addr_range_matcher against a cycle-level reference model.
module tb_addr_range_matcher;

    localparam int NW     = 4;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_sel;
    logic [31:0] cfg_lo;
    logic [31:0] cfg_hi;
    logic [1:0]  cfg_mode;
    logic        valid;
    logic [31:0] B;
    logic        hit;
    logic [NW-1:0] hit_vec;
    logic [3:0]  cnt_sel;
    logic        cnt_clr;
    logic [CW-1:0] cnt_out;

    always #5 clk = ~clk;

    addr_range_matcher #(
        .WIDTH(32), .NUM_WIN(NW), .CNT_WIDTH(CW), .SEL_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_mode(cfg_mode),
        .valid(valid), .B(B),
        .hit(hit), .hit_vec(hit_vec),
        .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out)
    );

    // Reference model: window table, per-window counts, and a two-deep delay line of match vectors.
    logic [31:0] m_lo   [NW];
    logic [31:0] m_hi   [NW];
    logic [1:0]  m_mode [NW];
    int          m_cnt  [NW];
    int          m_cnt_out;
    logic [NW-1:0] q[$];
    logic [NW-1:0] cmp_hv;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit win_match(input int w, input logic [31:0] b);
        bit in_rng;
        in_rng = (b >= m_lo[w]) && (b <= m_hi[w]);
        if (m_mode[w] == 2'b01) return in_rng;
        if (m_mode[w] == 2'b10) return !in_rng;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_lo[w]   = '1;
            m_hi[w]   = '1;
            m_mode[w] = 2'b00;
            m_cnt[w]  = 0;
        end
        m_cnt_out = 0;
        q.delete();
    endtask

    task automatic model_step();
        logic [NW-1:0] old_hv;
        logic [NW-1:0] vec;
        old_hv = (q.size() == 2) ? q[0] : '0;
        vec = '0;
        m_cnt_out = (int'(cnt_sel) < NW) ? m_cnt[cnt_sel] : 0;
        for (int w = 0; w < NW; w++) begin
            if (valid && win_match(w, B)) vec[w] = 1'b1;
        end
        for (int w = 0; w < NW; w++) begin
            if (cnt_clr) m_cnt[w] = 0;
            else if (old_hv[w] && m_cnt[w] < CNTMAX) m_cnt[w] = m_cnt[w] + 1;
        end
        if (cfg_we && int'(cfg_sel) < NW) begin
            m_lo[cfg_sel]   = cfg_lo;
            m_hi[cfg_sel]   = cfg_hi;
            m_mode[cfg_sel] = cfg_mode;
        end
        q.push_back(vec);
        if (q.size() > 2) void'(q.pop_front());
    endtask

    // Advance one clock; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_hv = (q.size() == 2) ? q[0] : '0;
            check("hit_vec", 32'(hit_vec), 32'(cmp_hv));
            check("hit", 32'(hit), 32'(|cmp_hv));
            check("cnt_out", 32'(cnt_out), 32'(m_cnt_out));
        end
    end

    task automatic cfg(input int sel, input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] mode);
        cfg_we = 1'b1; cfg_sel = 4'(sel); cfg_lo = lo; cfg_hi = hi; cfg_mode = mode; valid = 1'b0;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic addr(input logic [31:0] b);
        valid = 1'b1; B = b;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_lo = '0; cfg_hi = '0; cfg_mode = '0;
        valid = 1'b0; B = '0; cnt_sel = '0; cnt_clr = 1'b0;
        #1 reset = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        chk_en = 1'b1;
        check("rst_hit", 32'(hit), 0);
        check("rst_hit_vec", 32'(hit_vec), 0);
        check("rst_cnt_out", 32'(cnt_out), 0);

        // Inside window 0x1000..0x1FFF: boundaries either side.
        cfg(0, 32'h1000, 32'h1FFF, 2'b01);
        addr(32'h0FFF);
        addr(32'h1000);  check("w0_below", 32'(hit), 0);
        addr(32'h1FFF);  check("w0_lo", 32'(hit), 1);
        addr(32'h2000);  check("w0_hi", 32'(hit), 1);
        valid = 1'b0;
        tick();          check("w0_above", 32'(hit), 0);
        tick();
        tick();          check("w0_count", 32'(cnt_out), 2);

        // Outside window 0x10..0x20.
        cfg(1, 32'h10, 32'h20, 2'b10);
        addr(32'h0F);
        addr(32'h10);    check("w1_below", 32'(hit_vec[1]), 1);
        addr(32'h21);    check("w1_lo", 32'(hit_vec[1]), 0);
        valid = 1'b0;
        tick();          check("w1_above", 32'(hit_vec[1]), 1);

        // Empty windows (lo > hi), with mode 11 acting as off.
        cfg(0, 32'h0, 32'h0, 2'b00);
        cfg(1, 32'h10, 32'h20, 2'b11);
        cfg(2, 32'h50, 32'h40, 2'b01);
        cfg(3, 32'h50, 32'h40, 2'b10);
        addr(32'h48);
        valid = 1'b0;
        tick();          check("empty_win", 32'(hit_vec), 32'b1000);

        // Write and address in the same cycle: old config applies.
        cfg(3, 32'h0, 32'h0, 2'b00);
        cfg_we = 1'b1; cfg_sel = 4'd0; cfg_lo = 32'h0; cfg_hi = 32'hF; cfg_mode = 2'b01;
        valid = 1'b1; B = 32'h5;
        tick();
        cfg_we = 1'b0;
        tick();          check("same_cycle_cfg", 32'(hit), 0);
        valid = 1'b0;
        tick();          check("next_cycle_cfg", 32'(hit), 1);

        // Out-of-range window select must be ignored.
        cfg(4, 32'h0, 32'hFFFF_FFFF, 2'b01);
        cfg(9, 32'h0, 32'hFFFF_FFFF, 2'b10);
        addr(32'h100);
        valid = 1'b0;
        tick();          check("bad_sel_ignored", 32'(hit), 0);

        // Saturation after 17 hits, then clear coinciding with an increment.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int k = 0; k < 17; k++) addr(32'h5);
        valid = 1'b0;
        tick(); tick(); tick();
        check("cnt_saturate", 32'(cnt_out), 15);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        addr(32'h5); addr(32'h5); addr(32'h5);
        valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();          check("clr_wins", 32'(cnt_out), 0);
        tick();          check("cnt_after_clr", 32'(cnt_out), 1);
        cnt_sel = 4'd6;
        tick();          check("cnt_sel_oob", 32'(cnt_out), 0);
        cnt_sel = 4'd0;

        // Reset the cycle after a matching address is sampled.
        addr(32'h5);
        valid = 1'b0; reset = 1'b0;
        model_reset();
        #1;              check("rst_async_hit", 32'(hit), 0);
        tick();          check("rst_hold_hit", 32'(hit), 0);
        tick();
        reset = 1'b1;
        tick();          check("post_rst_hit", 32'(hit), 0);
        tick();          check("post_rst_vec", 32'(hit_vec), 0);
        check("post_rst_cnt", 32'(cnt_out), 0);
        addr(32'hFFFF_FFFF);
        valid = 1'b0;
        tick();          check("first_addr_off", 32'(hit), 0);

        // Randomised traffic; the negedge compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_sel  = 4'($urandom_range(0, 5));
            cfg_lo   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cfg_hi   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cfg_mode = 2'($urandom_range(0, 3));
            valid    = ($urandom_range(0, 3) != 0);
            B        = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 300));
            cnt_sel  = 4'($urandom_range(0, 5));
            cnt_clr  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                model_reset();
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end
        cfg_we = 1'b0; valid = 1'b0; cnt_clr = 1'b0;
        tick(); tick(); tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
